// File: rtl/nms_seq_ctrl.sv
// Sequencer for the NMS core: programs thresholds, feeds bboxes, drains kept indices.
// Optional watchdog (adds port err) enabled by defining NMS_SEQ_WDT_EN.
module nms_seq_ctrl #(
    parameter int BBOX_DATA_WIDTH  = 64,
    parameter int BBOX_IND_WIDTH   = 14,
    parameter int REG_DATA_WIDTH   = 32,
    parameter int REG_ADDR_WIDTH   = 4,
    parameter int IOU_THRESH_WIDTH = 16,
    parameter int MEM_ADDR_WIDTH   = 10,
    parameter int WDT_WIDTH        = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic [BBOX_IND_WIDTH-1:0]   cfg_num_pred,
    input  logic [IOU_THRESH_WIDTH-1:0] cfg_iou_thresh,
    input  logic [IOU_THRESH_WIDTH-1:0] cfg_s_thresh,
    output logic                        busy,
    output logic                        done,
    output logic                        mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
    input  logic [BBOX_DATA_WIDTH-1:0]  mem_rdata,
    output logic                        reg_ren,
    output logic [REG_ADDR_WIDTH-1:0]   reg_addr,
    output logic [REG_DATA_WIDTH-1:0]   reg_data,
    input  logic                        pbox_ready,
    output logic [BBOX_DATA_WIDTH-1:0]  pred_bbox_data,
    input  logic                        tvalid,
    input  logic                        tlast,
    output logic                        tready,
    input  logic [BBOX_IND_WIDTH-1:0]   bbox_index,
    input  logic                        done_int,
    output logic                        res_valid,
    output logic [BBOX_IND_WIDTH-1:0]   res_index,
    output logic [BBOX_IND_WIDTH-1:0]   res_cnt
`ifdef NMS_SEQ_WDT_EN
   ,output logic                        err
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_ZERO, S_CFG_IOU, S_GAP1, S_CFG_S, S_PREFETCH, S_LOAD0,
        S_CFG_START, S_FEED, S_DRAIN, S_WAIT_DONE, S_CLEAR
    } state_t;

    state_t state, state_nxt;

    logic [BBOX_IND_WIDTH-1:0]   num_pred_q, k;
    logic [IOU_THRESH_WIDTH-1:0] iou_q, s_q;
    logic load_pend, pbox_prev, tv_prev, tready_q, tlast_seen;
    logic start_acc, win, fall, feed_rd, accept, wdt_exp;

    assign start_acc = (state == S_IDLE) && start;
    assign win       = (state == S_CFG_START) || (state == S_FEED) || (state == S_DRAIN);
    assign fall      = pbox_prev && !pbox_ready;
    assign feed_rd   = (state == S_FEED) && fall && (k < num_pred_q);
    assign tready    = tready_q && win;
    assign accept    = tready && tvalid;
    assign busy      = (state != S_IDLE);

`ifdef NMS_SEQ_WDT_EN
    logic [WDT_WIDTH-1:0] wdt;

    // Any sign of life from the core restarts the count; expiry forces CLEAR.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wdt <= '0;
            err <= 1'b0;
        end else begin
            if (state == S_IDLE || pbox_prev != pbox_ready || accept || done_int)
                wdt <= '0;
            else
                wdt <= wdt + 1'b1;
            if (start_acc)
                err <= 1'b0;
            else if (wdt_exp)
                err <= 1'b1;
        end
    end

    assign wdt_exp = (&wdt) && (state != S_CLEAR) && (state != S_IDLE);
`else
    logic unused_wdt;
    assign unused_wdt = |WDT_WIDTH;
    assign wdt_exp    = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = (cfg_num_pred == '0) ? S_ZERO : S_CFG_IOU;
            S_ZERO:      state_nxt = S_IDLE;
            S_CFG_IOU:   state_nxt = S_GAP1;
            S_GAP1:      state_nxt = S_CFG_S;
            S_CFG_S:     state_nxt = S_PREFETCH;
            S_PREFETCH:  state_nxt = S_LOAD0;
            S_LOAD0:     state_nxt = S_CFG_START;
            S_CFG_START: state_nxt = S_FEED;
            S_FEED:      if (k == num_pred_q && !load_pend) state_nxt = S_DRAIN;
            S_DRAIN:     if (tlast_seen) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (done_int) state_nxt = S_CLEAR;
            S_CLEAR:     state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        if (wdt_exp) state_nxt = S_CLEAR;
    end

    always_comb begin
        reg_ren  = 1'b0;
        reg_addr = '0;
        reg_data = '0;
        mem_ren  = 1'b0;
        mem_addr = '0;
        done     = 1'b0;
        case (state)
            S_ZERO:      done = 1'b1;
            S_CFG_IOU: begin
                reg_ren  = 1'b1;
                reg_addr = REG_ADDR_WIDTH'(4);
                reg_data = REG_DATA_WIDTH'(iou_q);
            end
            S_CFG_S: begin
                reg_ren  = 1'b1;
                reg_addr = REG_ADDR_WIDTH'(8);
                reg_data = REG_DATA_WIDTH'(s_q);
            end
            S_PREFETCH:  mem_ren = 1'b1;
            S_CFG_START: begin
                reg_ren  = 1'b1;
                reg_data = REG_DATA_WIDTH'({num_pred_q, 1'b1});
            end
            S_FEED: begin
                mem_ren  = feed_rd;
                mem_addr = feed_rd ? k[MEM_ADDR_WIDTH-1:0] : '0;
            end
            S_CLEAR: begin
                reg_ren = 1'b1;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    // A fall can never occur the cycle after another, so a load never overlaps a read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            num_pred_q     <= '0;
            iou_q          <= '0;
            s_q            <= '0;
            k              <= '0;
            load_pend      <= 1'b0;
            pbox_prev      <= 1'b0;
            pred_bbox_data <= '0;
            tv_prev        <= 1'b0;
            tready_q       <= 1'b0;
            tlast_seen     <= 1'b0;
            res_valid      <= 1'b0;
            res_index      <= '0;
            res_cnt        <= '0;
        end else begin
            pbox_prev <= pbox_ready;
            load_pend <= feed_rd;
            if (start_acc) begin
                num_pred_q <= cfg_num_pred;
                iou_q      <= cfg_iou_thresh;
                s_q        <= cfg_s_thresh;
            end
            if (state == S_LOAD0 || load_pend)
                pred_bbox_data <= mem_rdata;
            if (state == S_CFG_START)
                k <= BBOX_IND_WIDTH'(1);
            else if (load_pend)
                k <= k + 1'b1;
            // tready needs two fresh tvalid cycles; the tready cycle itself restarts the count.
            tv_prev  <= win && tvalid && !tready;
            tready_q <= win && !tlast_seen && tvalid && tv_prev && !tready;
            res_valid <= accept;
            if (accept)
                res_index <= bbox_index;
            if (start_acc)
                res_cnt <= '0;
            else if (accept && !(&res_cnt))
                res_cnt <= res_cnt + 1'b1;
            if (start_acc)
                tlast_seen <= 1'b0;
            else if (accept && tlast)
                tlast_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nms_seq_ctrl.sv
// Bench for nms_seq_ctrl: event-queue model of register writes, bbox feed and index drain.
module tb_nms_seq_ctrl;

    logic        clk, resetn, start;
    logic [13:0] cfg_num_pred;
    logic [15:0] cfg_iou_thresh, cfg_s_thresh;
    logic        busy, done, mem_ren, reg_ren, pbox_ready, tvalid, tlast, tready;
    logic        done_int, res_valid;
    logic [9:0]  mem_addr;
    logic [63:0] mem_rdata, pred_bbox_data;
    logic [3:0]  reg_addr;
    logic [31:0] reg_data;
    logic [13:0] bbox_index, res_index, res_cnt;
`ifdef NMS_SEQ_WDT_EN
    logic        err;
`endif

    nms_seq_ctrl dut (
        .clk(clk), .resetn(resetn), .start(start),
        .cfg_num_pred(cfg_num_pred), .cfg_iou_thresh(cfg_iou_thresh), .cfg_s_thresh(cfg_s_thresh),
        .busy(busy), .done(done), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .reg_ren(reg_ren), .reg_addr(reg_addr), .reg_data(reg_data),
        .pbox_ready(pbox_ready), .pred_bbox_data(pred_bbox_data),
        .tvalid(tvalid), .tlast(tlast), .tready(tready), .bbox_index(bbox_index),
        .done_int(done_int), .res_valid(res_valid), .res_index(res_index), .res_cnt(res_cnt)
`ifdef NMS_SEQ_WDT_EN
       ,.err(err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] mem [0:15];
    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr[3:0]];

    typedef struct packed { logic [3:0] a; logic [31:0] d; } wr_t;
    wr_t         exp_wr[$];
    logic [63:0] exp_bb[$];
    int          exp_idx[$];
    int          wr_cyc[$];
    int          checks = 0, errors = 0;
    int          model_cnt, mren_cnt, st_cyc;
    logic [63:0] pred_prev;
    bit          tr_d1, tv_d1, tv_d2;
    wr_t         w;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event not seen within cycle bound", nm);
    endtask

    // Per-cycle comparison of every observable event against the expectation queues.
    always @(negedge clk) begin
        if (resetn) begin
            if (reg_ren) begin
                wr_cyc.push_back(cyc);
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL reg_write_unexpected: got addr %h data %h, required none", reg_addr, reg_data);
                end else begin
                    w = exp_wr.pop_front();
                    chk("reg_addr", 64'(reg_addr), 64'(w.a));
                    chk("reg_data", 64'(reg_data), 64'(w.d));
                end
            end
            if (pred_bbox_data !== pred_prev) begin
                if (exp_bb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pred_unexpected: got %h, required no change", pred_bbox_data);
                end else
                    chk("pred_bbox_data", pred_bbox_data, exp_bb.pop_front());
            end
            if (res_valid) begin
                if (exp_idx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL res_unexpected: got index %0d, required none", res_index);
                end else
                    chk("res_index", 64'(res_index), 64'(exp_idx.pop_front()));
                model_cnt++;
                chk("res_cnt", 64'(res_cnt), 64'(model_cnt));
            end
            if (tready) begin
                chk("tready_gap", 64'(tr_d1), 64'(0));
                chk("tready_after_two_valid", 64'(tv_d1 && tv_d2), 64'(1));
            end
            if (!busy) chk("tready_idle", 64'(tready), 64'(0));
            if (mem_ren) mren_cnt++;
        end
        pred_prev = pred_bbox_data;
        tr_d1     = tready;
        tv_d2     = tv_d1;
        tv_d1     = tvalid;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int np, input logic [15:0] iou, input logic [15:0] s,
                             input logic [31:0] start_word);
        exp_wr.push_back({4'd4, 32'(iou)});
        exp_wr.push_back({4'd8, 32'(s)});
        exp_wr.push_back({4'd0, start_word});
        exp_wr.push_back({4'd0, 32'd0});
        for (int i = 0; i < np; i++) exp_bb.push_back(mem[i]);
        wr_cyc.delete();
        model_cnt = 0;
        mren_cnt = 0;
        cfg_num_pred = 14'(np);
        cfg_iou_thresh = iou;
        cfg_s_thresh = s;
        start = 1'b1;
        st_cyc = cyc;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_cfg_write();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (reg_ren && reg_addr == 4'd0) seen = 1;
        end
        if (!seen) tmo("start_reg_write");
        else begin
            chk("start_write_latency", 64'(cyc - st_cyc), 64'd6);
            chk("pred_mem0_at_start_write", pred_bbox_data, mem[0]);
            if (wr_cyc.size() >= 2) begin
                chk("iou_write_latency", 64'(wr_cyc[0] - st_cyc), 64'd1);
                chk("s_write_latency", 64'(wr_cyc[1] - st_cyc), 64'd3);
            end else
                tmo("threshold_writes");
        end
        step(1);
    endtask

    task automatic pbox_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            pbox_ready = 1'b1;
            step(2);
            pbox_ready = 1'b0;
            step(3);
        end
    endtask

    task automatic send_idx(input int idx, input bit last);
        bit ok = 0;
        tvalid = 1'b1;
        bbox_index = 14'(idx);
        tlast = last;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (tready) ok = 1;
        end
        step(1);
        tvalid = 1'b0;
        tlast = 1'b0;
        if (!ok) tmo("index_accept");
        step(1);
    endtask

    task automatic finish_run(input int exp_cnt);
        bit seen = 0;
        done_int = 1'b1;
        step(1);
        done_int = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) tmo("done_pulse");
        else begin
            chk("clear_write_with_done", 64'(reg_ren), 64'd1);
            chk("final_res_cnt", 64'(res_cnt), 64'(exp_cnt));
            @(negedge clk);
            chk("busy_after_done", 64'(busy), 64'd0);
            chk("done_one_cycle", 64'(done), 64'd0);
        end
        chk("reg_writes_left", 64'(exp_wr.size()), 64'd0);
        chk("bbox_loads_left", 64'(exp_bb.size()), 64'd0);
        chk("indices_left", 64'(exp_idx.size()), 64'd0);
        step(1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 64'h1000_0000_0000_0001 + 64'(i) * 64'h0000_0101_0101_0101;
        resetn = 1'b0; start = 1'b0; cfg_num_pred = '0; cfg_iou_thresh = '0; cfg_s_thresh = '0;
        pbox_ready = 1'b0; tvalid = 1'b0; tlast = 1'b0; bbox_index = '0; done_int = 1'b0;
        mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_tready", 64'(tready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_cnt", 64'(res_cnt), 64'd0);
        chk("rst_reg_ren", 64'(reg_ren), 64'd0);
        chk("rst_mem_ren", 64'(mem_ren), 64'd0);
        chk("rst_pred", pred_bbox_data, 64'd0);
        step(1);
        resetn = 1'b1;
        step(2);

        // tvalid while idle must be ignored
        tvalid = 1'b1; bbox_index = 14'd7;
        step(4);
        tvalid = 1'b0;
        step(1);

        // Run 1: num_pred 10, start word 0x15; a second start while busy is ignored
        start_run(10, 16'h3800, 16'h3A66, 32'h15);
        step(1);
        start = 1'b1; cfg_num_pred = 14'd0; cfg_iou_thresh = 16'hFFFF;
        step(1);
        start = 1'b0;
        wait_cfg_write();
        exp_idx.push_back(0); exp_idx.push_back(5); exp_idx.push_back(9);
        fork
            pbox_pulses(10);
            begin
                step(3);
                send_idx(0, 1'b0);
                send_idx(5, 1'b0);
                send_idx(9, 1'b1);
            end
        join
        step(3);
        chk("pred_last_mem9", pred_bbox_data, mem[9]);
        chk("mem_ren_count_run1", 64'(mren_cnt), 64'd10);
        finish_run(3);

        // Run 2: num_pred 3, start word 0x7
        start_run(3, 16'h1234, 16'h0001, 32'h7);
        wait_cfg_write();
        exp_idx.push_back(2);
        fork
            pbox_pulses(3);
            send_idx(2, 1'b1);
        join
        step(2);
        chk("pred_last_mem2", pred_bbox_data, mem[2]);
        chk("mem_ren_count_run2", 64'(mren_cnt), 64'd3);
        finish_run(1);

        // Run 3: num_pred 0 -> done next cycle, no NMS activity
        mren_cnt = 0;
        cfg_num_pred = 14'd0;
        start = 1'b1;
        @(negedge clk);
        chk("zero_done_early", 64'(done), 64'd0);
        step(1);
        start = 1'b0;
        @(negedge clk);
        chk("zero_done_pulse", 64'(done), 64'd1);
        @(negedge clk);
        chk("zero_done_one_cycle", 64'(done), 64'd0);
        chk("zero_idle", 64'(busy), 64'd0);
        chk("zero_no_mem_ren", 64'(mren_cnt), 64'd0);
        step(1);

        // Run 4: async reset in the middle of FEED
        start_run(10, 16'h3C00, 16'h2000, 32'h15);
        wait_cfg_write();
        pbox_pulses(2);
        chk("pred_before_reset", pred_bbox_data, mem[2]);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_pred", pred_bbox_data, 64'd0);
        chk("mid_rst_mem_ren", 64'(mem_ren), 64'd0);
        chk("mid_rst_reg_ren", 64'(reg_ren), 64'd0);
        chk("mid_rst_tready", 64'(tready), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        exp_wr.delete(); exp_bb.delete(); exp_idx.delete();
        step(2);
        resetn = 1'b1;
        step(2);
        chk("post_rst_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
